plot_raster_stream: RTL and testbench
=====================================

Name: plot_raster_stream

Overview:
- Parametrised successor of the 4x4 serial plotter: stores a ROWS x COLS one-bit raster of incoming samples, one sample per column.
- Streams the raster serially as frames of ROWS*COLS bits, each frame flagged by a sync pulse.
- Adds full-column writes, a scroll mode, synchronous clear and out-of-range detection.
- Sits between the sample quantiser (row coordinate per sample) and the serial display driver.

Parameters:
- COLS, 4, raster width in columns (>= 2, need not be a power of 2).
- ROWS, 4, raster height in rows (>= 2, need not be a power of 2).
- Derived, not overridable: N = ROWS*COLS; CW = $clog2(COLS); RW = $clog2(ROWS); PW = $clog2(N).

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- plotcoord_i  in  RW  row index of the sample; row 0 is the bottom row.
- plotdata_i  in  1  pixel value written at (plotcoord_i, current column).
- newdata_i  in  1  sample strobe, one sample per high cycle.
- mode_i  in  1  0 = wrap, 1 = scroll; sampled on each newdata_i.
- clear_i  in  1  synchronous clear of the raster store.
- video_sync_o  out  1  high for the first bit of each frame.
- video_data_o  out  1  serial pixel stream.
- current_column_o  out  CW  column the next sample will write.
- coord_err_o  out  1  one-cycle pulse when a sample has plotcoord_i >= ROWS.

Behaviour:
- Reset (rst_i high at an edge): store, snapshot, pixel counter, column counter, filled flag and all outputs go to 0. Reset overrides all other inputs. A frame interrupted by reset is abandoned.
- Bit index of pixel (r, c) = (ROWS-1-r)*COLS + c. The top row is sent first.
- Column write: on newdata_i with a valid coordinate, the whole target column is rewritten. Bit (plotcoord_i, col) = plotdata_i, and every other row of that column = 0.
- Wrap mode: column counter goes 0..COLS-1 and wraps to 0. Old columns are overwritten in place.
- Filled flag: set when column COLS-1 is written in either mode.
- Scroll mode with filled=1: every row shifts one column left (column 0 dropped) and the new sample is written into column COLS-1. The column counter holds at COLS-1.
- Scroll mode with filled=0: behaves exactly like wrap mode.
- Switching scroll to wrap: the next sample goes to (counter+1) mod COLS, so from COLS-1 it wraps to 0.
- Out-of-range coordinate (plotcoord_i >= ROWS): the store and column counter are unchanged, and coord_err_o = 1 on the next cycle.
- clear_i: zeroes the store, column counter and filled flag on the next edge. clear_i and newdata_i in the same cycle: clear wins and the sample is dropped, with no coord_err_o. clear_i does not affect the frame already in flight.
- Serializer: pixel counter runs 0..N-1 and wraps, free-running.
  - When the counter is 0: snapshot <= store, video_sync_o <= 1, video_data_o <= store[0].
  - Otherwise: video_sync_o <= 0, video_data_o <= snapshot[counter].
- Outputs are registered with 1-cycle latency. The first sync appears at the first edge after reset deasserts, then every N cycles.
- A sample written in the same cycle the counter is 0 is not in that snapshot; it appears in the next frame.
- Store updates never alter a frame already being output.

Decomposition:
- Package plot_pkg: mode enum (PLOT_WRAP, PLOT_SCROLL), default COLS/ROWS constants, and a function pix_idx(row, col, ROWS, COLS) returning the bit index.
- Sub-module plot_serializer (parameter N): holds the pixel counter, snapshot register, and video_sync_o/video_data_o registers. It takes the store vector as input.
- The top level holds the store, column counter, filled flag, mode handling and error pulse.

Test Plan (COLS=ROWS=4):
- Reset: hold rst_i 3 cycles, then release. Outputs must be 0 during reset. Sync must go high at the first edge after release, then every 16 cycles, and current_column_o = 0.
- Wrap fill: write rows 3, 2, 1, 0 with data=1 into columns 0..3. The store must be 16'h8421, and the next frame must carry 1s on bits 0, 5, 10 and 15 after sync, with current_column_o = 0.
- Column overwrite: after the wrap fill, write row 0 with data=1. Column 0 must lose bit 0 and gain bit 12, giving store 16'h9420.
- Scroll: mode_i = 1, do the wrap fill, then write row 3 with data=1. The store must be 16'h4218 and current_column_o must hold at 3.
- Clear collision: assert clear_i and newdata_i together mid-frame. The current frame must be unchanged, the next frame all zeros, current_column_o = 0 and coord_err_o = 0.
- Snapshot isolation and error: with ROWS=3, send a sample with plotcoord_i = 3 mid-frame. coord_err_o must pulse for 1 cycle and the store must be unchanged. Then send a valid sample mid-frame; it must appear only after the next sync.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and helpers for the raster plotter.
// Pixel (row, col) maps to a flat bit index, top row first.
package plot_pkg;

  typedef enum logic {
    PLOT_WRAP   = 1'b0,
    PLOT_SCROLL = 1'b1
  } plot_mode_e;

  localparam int DEF_COLS = 4;
  localparam int DEF_ROWS = 4;

  function automatic int pix_idx(
    input int row,
    input int col,
    input int rows,
    input int cols
  );
    return (rows - 1 - row) * cols + col;
  endfunction

endpackage

// File: rtl/plot_serializer.sv
// Free-running frame serializer.
// Captures the raster at frame start and shifts it out bit by bit.
module plot_serializer #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] store_i,
  output logic         video_sync_o,
  output logic         video_data_o
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] cnt_q;
  logic [N-1:0]  snap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      snap_q       <= '0;
      video_sync_o <= 1'b0;
      video_data_o <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) begin
        snap_q       <= store_i;
        video_sync_o <= 1'b1;
        video_data_o <= store_i[0];
      end else begin
        video_sync_o <= 1'b0;
        video_data_o <= snap_q[cnt_q];
      end
    end
  end

endmodule

// File: rtl/plot_raster_stream.sv
// Column-addressed one-bit raster with wrap/scroll plotting,
// streamed out as sync-flagged serial frames.
module plot_raster_stream
  import plot_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [$clog2(ROWS)-1:0] plotcoord_i,
  input  logic                    plotdata_i,
  input  logic                    newdata_i,
  input  logic                    mode_i,
  input  logic                    clear_i,
  output logic                    video_sync_o,
  output logic                    video_data_o,
  output logic [$clog2(COLS)-1:0] current_column_o,
  output logic                    coord_err_o
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(N);
  localparam logic [RW:0]   ROWS_LIM = (RW + 1)'(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  logic [N-1:0]  store_q, store_d;
  logic [CW-1:0] col_q, col_d, wr_col;
  logic          filled_q, filled_d;
  logic          shifted_q, shifted_d;
  logic          err_q;
  logic          coord_ok, do_shift;
  logic [PW-1:0] dst, src;

  assign coord_ok = {1'b0, plotcoord_i} < ROWS_LIM;
  assign do_shift = (mode_i == PLOT_SCROLL) && filled_q;

  // After a scroll the counter parks on the last column; a wrap
  // sample then lands one column further on.
  assign wr_col = !shifted_q ? col_q :
                  (col_q == LAST_COL) ? '0 : col_q + 1'b1;

  always_comb begin
    store_d   = store_q;
    col_d     = col_q;
    filled_d  = filled_q;
    shifted_d = shifted_q;
    dst       = '0;
    src       = '0;
    if (clear_i) begin
      store_d   = '0;
      col_d     = '0;
      filled_d  = 1'b0;
      shifted_d = 1'b0;
    end else if (newdata_i && coord_ok) begin
      if (do_shift) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS - 1; c++) begin
            dst = PW'(pix_idx(r, c, ROWS, COLS));
            src = PW'(pix_idx(r, c + 1, ROWS, COLS));
            store_d[dst] = store_q[src];
          end
          dst = PW'(pix_idx(r, COLS - 1, ROWS, COLS));
          store_d[dst] = (RW'(r) == plotcoord_i) & plotdata_i;
        end
        col_d     = LAST_COL;
        shifted_d = 1'b1;
      end else begin
        for (int r = 0; r < ROWS; r++) begin
          dst = PW'(pix_idx(r, int'(wr_col), ROWS, COLS));
          store_d[dst] = (RW'(r) == plotcoord_i) & plotdata_i;
        end
        col_d     = (wr_col == LAST_COL) ? '0 : wr_col + 1'b1;
        filled_d  = filled_q | (wr_col == LAST_COL);
        shifted_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      store_q   <= '0;
      col_q     <= '0;
      filled_q  <= 1'b0;
      shifted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      store_q   <= store_d;
      col_q     <= col_d;
      filled_q  <= filled_d;
      shifted_q <= shifted_d;
      err_q     <= newdata_i & ~clear_i & ~coord_ok;
    end
  end

  assign current_column_o = col_q;
  assign coord_err_o      = err_q;

  plot_serializer #(
    .N(N)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .store_i     (store_q),
    .video_sync_o(video_sync_o),
    .video_data_o(video_data_o)
  );

endmodule

// File: tb/tb_plot_raster_stream.sv
// Bench for plot_raster_stream: a 4x4 and a 4-col x 3-row
// instance share stimulus and are checked against a raster model.
module tb_plot_raster_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coord = '0;
  logic       pdata = 1'b0;
  logic       newd = 1'b0;
  logic       mode = 1'b0;
  logic       clr = 1'b0;

  logic       s4, d4, e4, s3, d3, e3;
  logic [1:0] c4, c3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  plot_raster_stream #(.COLS(4), .ROWS(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .plotcoord_i(coord), .plotdata_i(pdata),
    .newdata_i(newd), .mode_i(mode), .clear_i(clr),
    .video_sync_o(s4), .video_data_o(d4),
    .current_column_o(c4), .coord_err_o(e4)
  );

  plot_raster_stream #(.COLS(4), .ROWS(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .plotcoord_i(coord), .plotdata_i(pdata),
    .newdata_i(newd), .mode_i(mode), .clear_i(clr),
    .video_sync_o(s3), .video_data_o(d3),
    .current_column_o(c3), .coord_err_o(e3)
  );

  // model state, index 0 = 4x4 instance, 1 = 3-row instance
  logic        ras[2][4][4];
  int          mcol[2];
  bit          mfill[2];
  bit          mpark[2];
  logic [15:0] snapv[2];
  int          mk[2];
  logic        e_sync[2], e_data[2], e_err[2];
  int          rowsv[2] = '{4, 3};

  function automatic logic [15:0] flat(input int m);
    logic [15:0] f = '0;
    for (int r = 0; r < rowsv[m]; r++)
      for (int c = 0; c < 4; c++)
        f[(rowsv[m] - 1 - r) * 4 + c] = ras[m][r][c];
    return f;
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) ras[m][r][c] = 1'b0;
        mcol[m] = 0; mfill[m] = 0; mpark[m] = 0;
        snapv[m] = '0; mk[m] = 0;
        e_sync[m] = 0; e_data[m] = 0; e_err[m] = 0;
      end else begin
        int t;
        if (mk[m] == 0) begin
          snapv[m] = flat(m);
          e_sync[m] = 1'b1;
          e_data[m] = snapv[m][0];
        end else begin
          e_sync[m] = 1'b0;
          e_data[m] = snapv[m][mk[m]];
        end
        mk[m] = (mk[m] + 1) % (rowsv[m] * 4);
        e_err[m] = newd && !clr && (int'(coord) >= rowsv[m]);
        if (clr) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ras[m][r][c] = 1'b0;
          mcol[m] = 0; mfill[m] = 0; mpark[m] = 0;
        end else if (newd && int'(coord) < rowsv[m]) begin
          if (mode && mfill[m]) begin
            for (int r = 0; r < rowsv[m]; r++) begin
              for (int c = 0; c < 3; c++)
                ras[m][r][c] = ras[m][r][c + 1];
              ras[m][r][3] = (r == int'(coord)) && pdata;
            end
            mcol[m] = 3;
            mpark[m] = 1;
          end else begin
            t = mpark[m] ? (mcol[m] + 1) % 4 : mcol[m];
            for (int r = 0; r < rowsv[m]; r++)
              ras[m][r][t] = (r == int'(coord)) && pdata;
            if (t == 3) mfill[m] = 1;
            mcol[m] = (t + 1) % 4;
            mpark[m] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("sync4", 16'(s4), 16'(e_sync[0]));
    chk("data4", 16'(d4), 16'(e_data[0]));
    chk("col4", 16'(c4), 16'(mcol[0]));
    chk("err4", 16'(e4), 16'(e_err[0]));
    chk("sync3", 16'(s3), 16'(e_sync[1]));
    chk("data3", 16'(d3), 16'(e_data[1]));
    chk("col3", 16'(c3), 16'(mcol[1]));
    chk("err3", 16'(e3), 16'(e_err[1]));
  end

  task automatic sample(input logic [1:0] cd,
                        input logic dv, input logic md);
    @(negedge clk);
    coord = cd; pdata = dv; mode = md; newd = 1'b1;
    @(negedge clk);
    newd = 1'b0;
  endtask

  task automatic fill(input logic md);
    sample(2'd3, 1'b1, md);
    sample(2'd2, 1'b1, md);
    sample(2'd1, 1'b1, md);
    sample(2'd0, 1'b1, md);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  function automatic logic sy(input int m);
    return (m == 0) ? s4 : s3;
  endfunction

  function automatic logic dd(input int m);
    return (m == 0) ? d4 : d3;
  endfunction

  task automatic wait_sync(input int m);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sy(m)) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL sync_timeout: got none expected sync");
    end
  endtask

  task automatic capture(input int m, output logic [15:0] v);
    v = '0;
    @(posedge clk);
    wait_sync(m);
    v[0] = dd(m);
    for (int k = 1; k < rowsv[m] * 4; k++) begin
      @(negedge clk);
      v[k] = dd(m);
    end
  endtask

  initial begin
    logic [15:0] fr;
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_out", {12'b0, s4, d4, e4, 1'b0}, 16'h0);
    chk("rst_col", 16'(c4), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_sync", 16'(s4), 16'h1);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (s4) break;
    end
    chk("sync_period", 16'(cyc), 16'd16);

    fill(1'b0);
    chk("model_fill", flat(0), 16'h8421);
    capture(0, fr);
    chk("frame_fill", fr, 16'h8421);
    chk("col_wrap", 16'(c4), 16'h0);

    sample(2'd0, 1'b1, 1'b0);
    capture(0, fr);
    chk("frame_over", fr, 16'h9420);

    pulse_clear();
    fill(1'b1);
    sample(2'd3, 1'b1, 1'b1);
    chk("model_scroll", flat(0), 16'h4218);
    capture(0, fr);
    chk("frame_scroll", fr, 16'h4218);
    chk("col_hold", 16'(c4), 16'h3);
    sample(2'd0, 1'b1, 1'b0);
    capture(0, fr);
    chk("frame_unpark", fr, 16'h5208);
    chk("col_unpark", 16'(c4), 16'h1);

    wait_sync(0);
    repeat (5) @(negedge clk);
    clr = 1'b1; newd = 1'b1; coord = 2'd3; pdata = 1'b1;
    @(negedge clk);
    clr = 1'b0; newd = 1'b0;
    chk("clr_noerr", 16'(e3), 16'h0);
    capture(0, fr);
    chk("frame_clr", fr, 16'h0);
    chk("col_clr", 16'(c4), 16'h0);

    wait_sync(1);
    repeat (5) @(negedge clk);
    coord = 2'd3; pdata = 1'b1; mode = 1'b0; newd = 1'b1;
    @(negedge clk);
    newd = 1'b0;
    chk("err_pulse", 16'(e3), 16'h1);
    @(negedge clk);
    chk("err_end", 16'(e3), 16'h0);
    chk("err_col", 16'(c3), 16'h0);
    capture(1, fr);
    chk("frame_err", fr, 16'h0);

    wait_sync(1);
    repeat (5) @(negedge clk);
    sample(2'd2, 1'b1, 1'b0);
    capture(1, fr);
    chk("frame_iso", fr, 16'h001);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
